// File: rtl/apb_master_arbiter.sv
// Two-requester APB arbiter with round-robin grant, driving one downstream APB slave.
// Define APB_ARB_TIMEOUT_EN to add an ACCESS-phase timeout (TIMEOUT_CYCLES) with a sticky timeout_o flag.
module apb_master_arbiter #(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      apb_pclk_i,
  input  logic                      apb_preset_ni,
  input  logic                      s0_psel_i,
  input  logic                      s0_penable_i,
  input  logic                      s0_pwrite_i,
  input  logic [APB_ADDR_WIDTH-1:0] s0_paddr_i,
  input  logic [APB_DATA_WIDTH-1:0] s0_pwdata_i,
  output logic [APB_DATA_WIDTH-1:0] s0_prdata_o,
  output logic                      s0_pready_o,
  input  logic                      s1_psel_i,
  input  logic                      s1_penable_i,
  input  logic                      s1_pwrite_i,
  input  logic [APB_ADDR_WIDTH-1:0] s1_paddr_i,
  input  logic [APB_DATA_WIDTH-1:0] s1_pwdata_i,
  output logic [APB_DATA_WIDTH-1:0] s1_prdata_o,
  output logic                      s1_pready_o,
  output logic                      m_psel_o,
  output logic                      m_penable_o,
  output logic                      m_pwrite_o,
  output logic [APB_ADDR_WIDTH-1:0] m_paddr_o,
  output logic [APB_DATA_WIDTH-1:0] m_pwdata_o,
  input  logic [APB_DATA_WIDTH-1:0] m_prdata_i,
  input  logic                      m_pready_i,
  output logic                      timeout_o,
  output logic [1:0]                fsm_state
);

  // Handshake: a requester raises psel and holds its controls until it sees its
  // pready high for one cycle; downstream, the transfer ends in the ACCESS cycle
  // where m_pready_i is sampled high.
  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2, RESP = 2'd3} state_t;

  state_t                    state;
  logic                      last_grant;
  logic                      grant;
  logic                      pick;
  logic                      done;
  logic [APB_DATA_WIDTH-1:0] resp_data;
  logic                      unused_inputs;

  assign fsm_state = state;

  // Round-robin: a tie goes to the port that did not win last time.
  always_comb begin
    pick = 1'b0;
    if (s0_psel_i && s1_psel_i) pick = ~last_grant;
    else if (s1_psel_i)         pick = 1'b1;
  end

`ifdef APB_ARB_TIMEOUT_EN
  logic [7:0] wait_cnt;
  logic       expired;

  assign unused_inputs = ^{s0_penable_i, s1_penable_i};

  always_comb begin
    expired   = (wait_cnt == 8'(TIMEOUT_CYCLES - 1));
    done      = m_pready_i;
    resp_data = m_prdata_i;
    if (!m_pready_i && expired) begin
      done      = 1'b1;
      resp_data = '1;
    end
  end

  always_ff @(posedge apb_pclk_i or negedge apb_preset_ni) begin
    if (!apb_preset_ni) begin
      wait_cnt  <= 8'd0;
      timeout_o <= 1'b0;
    end else if (state == SETUP) begin
      wait_cnt <= 8'd0;
    end else if (state == ACCESS && !m_pready_i) begin
      wait_cnt <= wait_cnt + 8'd1;
      if (expired) timeout_o <= 1'b1;
    end
  end
`else
  assign unused_inputs = ^{s0_penable_i, s1_penable_i, 8'(TIMEOUT_CYCLES)};
  assign timeout_o     = 1'b0;

  always_comb begin
    done      = m_pready_i;
    resp_data = m_prdata_i;
  end
`endif

  always_ff @(posedge apb_pclk_i or negedge apb_preset_ni) begin
    if (!apb_preset_ni) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      grant       <= 1'b0;
      m_psel_o    <= 1'b0;
      m_penable_o <= 1'b0;
      m_pwrite_o  <= 1'b0;
      m_paddr_o   <= '0;
      m_pwdata_o  <= '0;
      s0_pready_o <= 1'b0;
      s1_pready_o <= 1'b0;
      s0_prdata_o <= '0;
      s1_prdata_o <= '0;
    end else begin
      s0_pready_o <= 1'b0;
      s1_pready_o <= 1'b0;
      case (state)
        IDLE: begin
          if (s0_psel_i || s1_psel_i) begin
            grant      <= pick;
            m_paddr_o  <= pick ? s1_paddr_i  : s0_paddr_i;
            m_pwrite_o <= pick ? s1_pwrite_i : s0_pwrite_i;
            m_pwdata_o <= pick ? s1_pwdata_i : s0_pwdata_i;
            m_psel_o   <= 1'b1;
            state      <= SETUP;
          end
        end
        SETUP: begin
          m_penable_o <= 1'b1;
          state       <= ACCESS;
        end
        ACCESS: begin
          if (done) begin
            m_psel_o    <= 1'b0;
            m_penable_o <= 1'b0;
            if (grant) begin
              s1_pready_o <= 1'b1;
              s1_prdata_o <= resp_data;
            end else begin
              s0_pready_o <= 1'b1;
              s0_prdata_o <= resp_data;
            end
            state <= RESP;
          end
        end
        RESP: begin
          last_grant <= grant;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter: single read, round-robin ties, wait states,
// reset mid-ACCESS, and the timeout path when APB_ARB_TIMEOUT_EN is defined.
module tb_apb_master_arbiter;

  logic        clk;
  logic        rst_n;
  logic        s0_psel, s0_penable, s0_pwrite;
  logic [31:0] s0_paddr, s0_pwdata, s0_prdata;
  logic        s0_pready;
  logic        s1_psel, s1_penable, s1_pwrite;
  logic [31:0] s1_paddr, s1_pwdata, s1_prdata;
  logic        s1_pready;
  logic        m_psel, m_penable, m_pwrite;
  logic [31:0] m_paddr, m_pwdata, m_prdata;
  logic        m_pready;
  logic        timeout;
  logic [1:0]  fsm_state;

  int n_checks = 0;
  int n_fail   = 0;

  apb_master_arbiter #(
    .APB_ADDR_WIDTH(32),
    .APB_DATA_WIDTH(32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .apb_pclk_i   (clk),
    .apb_preset_ni(rst_n),
    .s0_psel_i    (s0_psel),
    .s0_penable_i (s0_penable),
    .s0_pwrite_i  (s0_pwrite),
    .s0_paddr_i   (s0_paddr),
    .s0_pwdata_i  (s0_pwdata),
    .s0_prdata_o  (s0_prdata),
    .s0_pready_o  (s0_pready),
    .s1_psel_i    (s1_psel),
    .s1_penable_i (s1_penable),
    .s1_pwrite_i  (s1_pwrite),
    .s1_paddr_i   (s1_paddr),
    .s1_pwdata_i  (s1_pwdata),
    .s1_prdata_o  (s1_prdata),
    .s1_pready_o  (s1_pready),
    .m_psel_o     (m_psel),
    .m_penable_o  (m_penable),
    .m_pwrite_o   (m_pwrite),
    .m_paddr_o    (m_paddr),
    .m_pwdata_o   (m_pwdata),
    .m_prdata_i   (m_prdata),
    .m_pready_i   (m_pready),
    .timeout_o    (timeout),
    .fsm_state    (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic req(input int port, input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    if (port == 0) begin
      s0_psel = 1'b1; s0_pwrite = wr; s0_paddr = addr; s0_pwdata = wdata;
    end else begin
      s1_psel = 1'b1; s1_pwrite = wr; s1_paddr = addr; s1_pwdata = wdata;
    end
  endtask

  int hits;
  int hit_at;

  initial begin
    rst_n = 1'b0;
    s0_psel = 0; s0_penable = 0; s0_pwrite = 0; s0_paddr = 0; s0_pwdata = 0;
    s1_psel = 0; s1_penable = 0; s1_pwrite = 0; s1_paddr = 0; s1_pwdata = 0;
    m_prdata = 0; m_pready = 0;
    tick(2);

    // reset state
    check("rst_m_psel", m_psel, 0);
    check("rst_m_penable", m_penable, 0);
    check("rst_m_paddr", m_paddr, 0);
    check("rst_s0_pready", s0_pready, 0);
    check("rst_s1_prdata", s1_prdata, 0);
    check("rst_timeout", timeout, 0);
    check("rst_state", fsm_state, 0);
    rst_n = 1'b1;

    // single zero-wait read from s0
    req(0, 1'b0, 32'h100, 32'h0);
    m_pready = 1'b1; m_prdata = 32'hCAFE0001;
    tick(1);
    check("rd_c1_psel", m_psel, 1);
    check("rd_c1_penable", m_penable, 0);
    check("rd_c1_paddr", m_paddr, 32'h100);
    check("rd_c1_pwrite", m_pwrite, 0);
    s0_penable = 1'b1;
    tick(1);
    check("rd_c2_penable", m_penable, 1);
    check("rd_c2_s0_pready", s0_pready, 0);
    tick(1);
    check("rd_c3_s0_pready", s0_pready, 1);
    check("rd_c3_s0_prdata", s0_prdata, 32'hCAFE0001);
    check("rd_c3_m_psel", m_psel, 0);
    check("rd_c3_s1_pready", s1_pready, 0);
    s0_psel = 0; s0_penable = 0; m_prdata = 32'h0;
    tick(1);
    check("rd_c4_s0_pready", s0_pready, 0);
    check("rd_c4_prdata_hold", s0_prdata, 32'hCAFE0001);
    check("rd_c4_state", fsm_state, 0);

    // simultaneous requests out of reset
    do_reset();
    req(0, 1'b0, 32'h10, 32'h0);
    req(1, 1'b0, 32'h14, 32'h0);
    m_pready = 1'b1; m_prdata = 32'h11111111;
    tick(1);
    check("rr1_first_addr", m_paddr, 32'h10);
    tick(2);
    check("rr1_s0_pready", s0_pready, 1);
    check("rr1_s0_prdata", s0_prdata, 32'h11111111);
    check("rr1_s1_waiting", s1_pready, 0);
    s0_psel = 0;
    tick(1);
    m_prdata = 32'h22222222;
    check("rr1_s1_pending", s1_pready, 0);
    tick(1);
    check("rr1_second_addr", m_paddr, 32'h14);
    tick(2);
    check("rr1_s1_pready", s1_pready, 1);
    check("rr1_s1_prdata", s1_prdata, 32'h22222222);
    check("rr1_s0_prdata_hold", s0_prdata, 32'h11111111);
    s1_psel = 0;
    tick(1);
    req(0, 1'b0, 32'h30, 32'h0);
    req(1, 1'b0, 32'h34, 32'h0);
    tick(1);
    check("rr2_first_addr", m_paddr, 32'h30);
    tick(2);
    check("rr2_s0_pready", s0_pready, 1);
    s0_psel = 0;
    tick(2);
    check("rr2_second_addr", m_paddr, 32'h34);
    tick(2);
    check("rr2_s1_pready", s1_pready, 1);
    s1_psel = 0;
    tick(1);

    // s1 write with 5 wait states
    req(1, 1'b1, 32'h20, 32'h12345678);
    m_pready = 1'b0; m_prdata = 32'hA5A5A5A5;
    hits = 0; hit_at = 0;
    for (int k = 1; k <= 9; k++) begin
      tick(1);
      if (k == 1) check("ws_pwrite", m_pwrite, 1);
      if (k <= 7) check($sformatf("ws_pwdata_c%0d", k), m_pwdata, 32'h12345678);
      if (k == 7) m_pready = 1'b1;
      if (s1_pready) begin
        hits++;
        hit_at = k;
      end
      if (k == 8) s1_psel = 0;
    end
    check("ws_pready_count", hits, 1);
    check("ws_pready_cycle", hit_at, 8);
    check("ws_write_rdata", s1_prdata, 32'hA5A5A5A5);

    // reset in the middle of ACCESS
    req(0, 1'b0, 32'h50, 32'h0);
    m_pready = 1'b0;
    tick(2);
    check("mid_in_access", fsm_state, 2);
    rst_n = 1'b0;
    #1;
    check("mid_m_psel", m_psel, 0);
    check("mid_m_penable", m_penable, 0);
    check("mid_m_paddr", m_paddr, 0);
    check("mid_s0_pready", s0_pready, 0);
    check("mid_state", fsm_state, 0);
    tick(1);
    rst_n = 1'b1;
    s0_psel = 0;
    req(1, 1'b0, 32'h40, 32'h0);
    m_pready = 1'b1; m_prdata = 32'h5A5A0001;
    tick(1);
    check("post_rst_paddr", m_paddr, 32'h40);
    tick(2);
    check("post_rst_s1_pready", s1_pready, 1);
    check("post_rst_s1_prdata", s1_prdata, 32'h5A5A0001);
    s1_psel = 0;
    tick(1);

    // downstream never ready
    req(0, 1'b0, 32'h60, 32'h0);
    m_pready = 1'b0; m_prdata = 32'h0BAD0BAD;
`ifdef APB_ARB_TIMEOUT_EN
    tick(5);
    check("to_c5_s0_pready", s0_pready, 0);
    check("to_c5_timeout", timeout, 0);
    tick(1);
    check("to_c6_s0_pready", s0_pready, 1);
    check("to_c6_prdata", s0_prdata, 32'hFFFFFFFF);
    check("to_c6_timeout", timeout, 1);
    check("to_c6_m_psel", m_psel, 0);
    s0_psel = 0;
    tick(3);
    check("to_sticky", timeout, 1);
    check("to_idle", fsm_state, 0);
    req(1, 1'b0, 32'h70, 32'h0);
    m_pready = 1'b1; m_prdata = 32'h77;
    tick(3);
    check("to_next_s1_prdata", s1_prdata, 32'h77);
    check("to_still_sticky", timeout, 1);
    s1_psel = 0;
`else
    tick(6);
    check("nto_still_access", fsm_state, 2);
    check("nto_s0_pready", s0_pready, 0);
    check("nto_timeout", timeout, 0);
    m_pready = 1'b1;
    tick(1);
    check("nto_s0_pready_late", s0_pready, 1);
    check("nto_s0_prdata", s0_prdata, 32'h0BAD0BAD);
    s0_psel = 0;
`endif
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
